// File: rtl/debounce_pkg.sv
// Shared constants, state type and sizing helper
// for the multi-channel input debouncer.
package debounce_pkg;

    localparam int DEB_TICK_DIV_100MHZ_2_5MS = 250000;
    localparam int DEB_SYNC_DEFAULT          = 2;

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } deb_state_e;

    function automatic int clog2_min1(input int v);
        int r;
        r = $clog2(v);
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/debounce_tick_gen.sv
// Shared sample-tick prescaler: one registered strobe
// every TICK_DIV clocks, first one TICK_DIV clocks after reset.
module debounce_tick_gen
    import debounce_pkg::*;
#(
    parameter int TICK_DIV = DEB_TICK_DIV_100MHZ_2_5MS
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);

    localparam int            CW   = clog2_min1(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= (cnt == LAST);
            cnt  <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/debounce_multi.sv
// N-channel debouncer: polarity fix, synchroniser, tick-qualified
// stability counter and registered edge pulses per channel.
module debounce_multi
    import debounce_pkg::*;
#(
    parameter int              N_CH         = 4,
    parameter int              SYNC_STAGES  = DEB_SYNC_DEFAULT,
    parameter int              TICK_DIV     = DEB_TICK_DIV_100MHZ_2_5MS,
    parameter int              STABLE_TICKS = 4,
    parameter logic [N_CH-1:0] ACTIVE_LOW   = '0
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [N_CH-1:0] raw_in,
    output logic [N_CH-1:0] level_out,
    output logic [N_CH-1:0] rise_pulse,
    output logic [N_CH-1:0] fall_pulse,
    output logic            tick
);

    localparam int            KW    = clog2_min1(STABLE_TICKS);
    localparam logic [KW-1:0] K_TOP = KW'(STABLE_TICKS - 1);

    logic [N_CH-1:0] sync_q [SYNC_STAGES];
    logic [N_CH-1:0] sync;

    debounce_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clock (clock),
        .reset (reset),
        .tick  (tick)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= raw_in ^ ACTIVE_LOW;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        deb_state_e    state;
        logic [KW-1:0] cnt;
        logic          lvl_q;
        logic          rise_q;
        logic          fall_q;

        // The tick seen on the cycle a mismatch starts is not counted.
        always_ff @(posedge clock) begin
            if (reset) begin
                state  <= ST_STABLE;
                cnt    <= '0;
                lvl_q  <= 1'b0;
                rise_q <= 1'b0;
                fall_q <= 1'b0;
            end else begin
                rise_q <= 1'b0;
                fall_q <= 1'b0;
                unique case (state)
                    ST_STABLE: begin
                        cnt <= '0;
                        if (sync[i] != lvl_q) begin
                            state <= ST_PENDING;
                        end
                    end
                    ST_PENDING: begin
                        if (sync[i] == lvl_q) begin
                            cnt   <= '0;
                            state <= ST_STABLE;
                        end else if (tick) begin
                            if (cnt == K_TOP) begin
                                lvl_q  <= ~lvl_q;
                                rise_q <= ~lvl_q;
                                fall_q <= lvl_q;
                                cnt    <= '0;
                                state  <= ST_STABLE;
                            end else begin
                                cnt <= cnt + KW'(1);
                            end
                        end
                    end
                    default: begin
                        cnt   <= '0;
                        state <= ST_STABLE;
                    end
                endcase
            end
        end

        assign level_out[i]  = lvl_q;
        assign rise_pulse[i] = rise_q;
        assign fall_pulse[i] = fall_q;
    end

endmodule

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi: two configurations against a
// run-length/tick-count model plus directed literal checks.
module tb_debounce_multi;

    localparam logic [3:0] AL = 4'b1000;
    localparam int DV[2] = '{4, 1};
    localparam int TV[2] = '{3, 1};

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] raw_in;
    logic [3:0] lvl_a, rise_a, fall_a;
    logic [3:0] lvl_b, rise_b, fall_b;
    logic       tick_a, tick_b;

    int compared   = 0;
    int mismatched = 0;

    always #5 clock = ~clock;

    debounce_multi #(
        .N_CH(4), .SYNC_STAGES(2), .TICK_DIV(4),
        .STABLE_TICKS(3), .ACTIVE_LOW(AL)
    ) dut_a (
        .clock(clock), .reset(reset), .raw_in(raw_in),
        .level_out(lvl_a), .rise_pulse(rise_a),
        .fall_pulse(fall_a), .tick(tick_a)
    );

    debounce_multi #(
        .N_CH(4), .SYNC_STAGES(2), .TICK_DIV(1),
        .STABLE_TICKS(1), .ACTIVE_LOW(AL)
    ) dut_b (
        .clock(clock), .reset(reset), .raw_in(raw_in),
        .level_out(lvl_b), .rise_pulse(rise_b),
        .fall_pulse(fall_b), .tick(tick_b)
    );

    task automatic chk(input string nm, input logic [3:0] act,
                       input logic [3:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %b expected %b at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic chk_range(input string nm, input int v,
                             input int lo, input int hi);
        compared++;
        if (v < lo || v > hi) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d..%0d",
                     nm, v, lo, hi);
        end
    endtask

    // Ticks visible to the channels at edges 1..x since reset
    function automatic int f_ticks(input int x, input int d);
        return (x >= 1) ? (x - 1) / d : 0;
    endfunction

    // Model: a channel flips once its synchronised input has differed
    // from the level continuously while STABLE_TICKS ticks were seen
    // after the edge where the difference first appeared.
    logic [3:0] m_lvl[2], m_rise[2], m_fall[2];
    logic       m_tick[2];
    bit         pend[2][4];
    int         mst[2][4];
    bit         model_ok = 1'b0;
    int         k;
    logic [3:0] sh0, sh1, fin;

    initial begin : model
        forever begin
            @(posedge clock);
            if (reset) begin
                k = 0; sh0 = '0; sh1 = '0;
                for (int c = 0; c < 2; c++) begin
                    m_lvl[c] = '0; m_rise[c] = '0;
                    m_fall[c] = '0; m_tick[c] = 1'b0;
                    for (int h = 0; h < 4; h++) pend[c][h] = 1'b0;
                end
            end else begin
                fin = sh1; sh1 = sh0; sh0 = raw_in ^ AL;
                k++;
                for (int c = 0; c < 2; c++) begin
                    m_tick[c] = (k % DV[c]) == 0;
                    m_rise[c] = '0; m_fall[c] = '0;
                    for (int h = 0; h < 4; h++) begin
                        if (fin[h] != m_lvl[c][h]) begin
                            if (!pend[c][h]) begin
                                pend[c][h] = 1'b1;
                                mst[c][h]  = k;
                            end else if (f_ticks(k, DV[c]) -
                                         f_ticks(mst[c][h], DV[c])
                                         >= TV[c]) begin
                                pend[c][h] = 1'b0;
                                m_lvl[c][h] = fin[h];
                                m_rise[c][h] = fin[h];
                                m_fall[c][h] = ~fin[h];
                            end
                        end else begin
                            pend[c][h] = 1'b0;
                        end
                    end
                end
            end
            model_ok = 1'b1;
        end
    end

    always @(negedge clock) begin
        if (model_ok) begin
            chk("a_level", lvl_a, m_lvl[0]);
            chk("a_rise", rise_a, m_rise[0]);
            chk("a_fall", fall_a, m_fall[0]);
            chk("a_tick", {3'b0, tick_a}, {3'b0, m_tick[0]});
            chk("b_level", lvl_b, m_lvl[1]);
            chk("b_rise", rise_b, m_rise[1]);
            chk("b_fall", fall_b, m_fall[1]);
            chk("b_tick", {3'b0, tick_b}, {3'b0, m_tick[1]});
            compared++;
            if ((rise_a & fall_a) != 4'b0) begin
                mismatched++;
                $display("FAIL a_rise_fall_both: got %b expected 0000",
                         rise_a & fall_a);
            end
        end
    end

    task automatic wait_bit(input int ch, input logic val,
                            input int maxn, output int n);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (lvl_a[ch] !== val && n < maxn);
    endtask

    int n;
    int p;

    initial begin
        reset  = 1'b1;
        raw_in = 4'b1000;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clock);
            chk("s1_tick", {3'b0, tick_a},
                (c % 4 == 0) ? 4'd1 : 4'd0);
        end
        chk("s1_level", lvl_a, 4'b0000);

        raw_in[1] = 1'b1;
        repeat (3) @(negedge clock);
        chk("b_lat_pre", {3'b0, lvl_b[1]}, 4'd0);
        @(negedge clock);
        chk("b_lat_lvl", {3'b0, lvl_b[1]}, 4'd1);
        chk("b_lat_rise", {3'b0, rise_b[1]}, 4'd1);
        raw_in[1] = 1'b0;
        repeat (20) @(negedge clock);

        raw_in[0] = 1'b1;
        wait_bit(0, 1'b1, 40, n);
        chk_range("s2_latency", n - 1, 11, 14);
        chk("s2_rise", rise_a, 4'b0001);
        chk("s2_others", {1'b0, lvl_a[3:1]}, 4'b0000);
        @(negedge clock);
        chk("s2_rise_off", rise_a, 4'b0000);

        raw_in[1] = 1'b1;
        repeat (6) @(negedge clock);
        raw_in[1] = 1'b0;
        repeat (20) @(negedge clock);
        chk("s3_glitch", {3'b0, lvl_a[1]}, 4'd0);
        raw_in[1] = 1'b1;
        repeat (7) @(negedge clock);
        raw_in[1] = 1'b0;
        @(negedge clock);
        raw_in[1] = 1'b1;
        wait_bit(1, 1'b1, 40, n);
        chk_range("s3_bounce_lat", n - 1, 11, 14);

        raw_in[0] = 1'b0;
        wait_bit(0, 1'b0, 40, n);
        chk("s4_fall", {3'b0, fall_a[0]}, 4'd1);
        chk_range("s4_fall_lat", n - 1, 11, 14);
        raw_in[3] = 1'b0;
        wait_bit(3, 1'b1, 40, n);
        chk("s4_rise3", {3'b0, rise_a[3]}, 4'd1);

        repeat (5) @(negedge clock);
        raw_in[0] = 1'b1;
        raw_in[2] = 1'b1;
        wait_bit(0, 1'b1, 40, n);
        chk("s5_level2", {3'b0, lvl_a[2]}, 4'd1);
        chk("s5_rise", rise_a & 4'b0101, 4'b0101);

        raw_in[1] = 1'b0;
        wait_bit(1, 1'b0, 40, n);
        repeat (3) @(negedge clock);
        raw_in[1] = 1'b1;
        repeat (10) @(negedge clock);
        chk("s6_pending", {3'b0, lvl_a[1]}, 4'd0);
        reset = 1'b1;
        @(negedge clock);
        chk("s6_rst_lvl", lvl_a, 4'b0000);
        chk("s6_rst_pulse", rise_a | fall_a, 4'b0000);
        chk("s6_rst_b", lvl_b | rise_b | fall_b, 4'b0000);
        reset = 1'b0;
        wait_bit(1, 1'b1, 40, n);
        chk_range("s6_requal", n, 11, 14);
        chk("s6_rise", {3'b0, rise_a[1]}, 4'd1);

        p = 5;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clock);
            if (c % 200 == 0) begin
                case ($urandom_range(0, 2))
                    0: p = 1;
                    1: p = 5;
                    default: p = 30;
                endcase
            end
            for (int h = 0; h < 4; h++) begin
                if ($urandom_range(0, 99) < p) raw_in[h] = ~raw_in[h];
            end
            reset = ($urandom_range(0, 699) == 0);
        end
        reset = 1'b0;
        repeat (20) @(negedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule

// File: doc/debounce_multi.md
Name: debounce_multi

Overview:
Parametrised N-channel button/switch debouncer, successor to the single-input board-level debouncer used on the reset pushbutton path.
- Each channel: synchroniser chain, glitch-rejecting stability counter, clean level output, one-cycle press/release pulses.
- All channels share one clock-enable prescaler.
- Sits between raw board inputs (buttons, DIP switches, BT status lines) and the clock/reset generation and SoC GPIO logic.

Parameters:
N_CH, 4, number of independent input channels (>=1)
SYNC_STAGES, 2, flip-flops in each input synchroniser (>=2)
TICK_DIV, 250000, clock cycles per sample tick (>=1); TICK_DIV=1 means tick every cycle
STABLE_TICKS, 4, consecutive ticks an input must differ from current level before the level flips (>=1)
ACTIVE_LOW, 0, bit vector [N_CH-1:0]; bit i=1 inverts raw input i before synchronisation

Ports:
clock  in  1  system clock; all logic is on its rising edge
reset  in  1  synchronous, active-high reset
raw_in  in  N_CH  asynchronous raw inputs
level_out  out  N_CH  debounced level per channel (post-polarity: 1 = asserted)
rise_pulse  out  N_CH  one-cycle pulse when level_out[i] goes 0->1
fall_pulse  out  N_CH  one-cycle pulse when level_out[i] goes 1->0
tick  out  1  prescaler strobe, for observation/test

Behaviour:
- Interface (decided): one clock `clock`. Reset `reset` is synchronous and active-high.
- Reset values:
  - All outputs 0.
  - Synchroniser flops 0, prescaler count 0, channel counters 0, all channel states STABLE.
- Prescaler:
  - cnt counts 0..TICK_DIV-1 and wraps to 0.
  - tick=1 in the cycle where cnt==TICK_DIV-1 (registered output).
  - First tick is TICK_DIV cycles after reset deasserts. TICK_DIV=1 gives tick=1 every cycle after reset.
  - Width: $clog2(TICK_DIV) bits, minimum 1.
- Polarity: s_i = raw_in[i] ^ ACTIVE_LOW[i], fed into a SYNC_STAGES-deep flop chain. sync[i] is the last stage.
- Per-channel FSM, two states:
  - STABLE: sync==level. Counter held at 0.
    - If sync!=level, go to PENDING in the same cycle the mismatch is seen.
  - PENDING: sync!=level.
    - Any cycle with sync==level (tick or not): counter := 0, go to STABLE. This is glitch rejection; no partial credit is kept.
    - On tick with sync!=level: if counter==STABLE_TICKS-1, then level:=~level, counter:=0, one pulse on rise_pulse or fall_pulse, go to STABLE. Otherwise counter++.
  - Counter width: $clog2(STABLE_TICKS), minimum 1. It never exceeds STABLE_TICKS-1.
- Pulses:
  - Registered, asserted in the same cycle level_out changes, exactly one cycle wide.
  - rise and fall are never both high for one channel.
- Latency from a clean raw edge to level_out change: SYNC_STAGES + between (STABLE_TICKS-1)*TICK_DIV+1 and STABLE_TICKS*TICK_DIV cycles, depending on prescaler phase.
- Channels are fully independent except for the shared tick. Simultaneous flips on several channels in one cycle are legal.
- Reset mid-operation: reset takes effect on the next clock edge regardless of state.
  - Pending counts are lost and levels return to 0. No pulses are generated by reset.
  - An input held asserted through reset re-qualifies normally and produces a rise_pulse.

Decomposition:
- Shared package debounce_pkg holds:
  - Function clog2_min1.
  - Default constants: DEB_TICK_DIV_100MHZ_2_5MS = 250000, DEB_SYNC_DEFAULT = 2.
- One natural sub-module: debounce_tick_gen (the prescaler, parameter TICK_DIV, ports clock/reset/tick).
- Channels are a generate loop inside debounce_multi; no per-channel module.

Test Plan:
All scenarios use N_CH=4, SYNC_STAGES=2, TICK_DIV=4, STABLE_TICKS=3, ACTIVE_LOW=4'b1000 unless noted.
1. Reset for 3 cycles with raw_in=4'b1000 (ch3 inactive because active-low), then hold 20 cycles -> level_out=0, no pulses, tick first seen exactly 4 cycles after reset falls, then every 4 cycles.
2. raw_in[0] 0->1 held 30 cycles -> level_out[0] rises between 11 and 14 cycles after the edge, rise_pulse[0] high exactly 1 cycle, same cycle as the rise; other channels unchanged.
3. raw_in[1] high for 6 cycles then low (glitch shorter than 3 ticks) -> level_out[1] stays 0, no pulses. Repeat with bounce: 1 for 7 cycles, 0 for 1 cycle, 1 held -> qualification restarts after the bounce.
4. Ch0 asserted and qualified, then raw_in[0] low held -> fall_pulse[0] one cycle, level_out[0]=0; ch3 raw 1->0 (active-low press) -> level_out[3]=1 with rise_pulse[3].
5. Ch0 and ch2 raw rise in the same cycle -> both level bits and both rise pulses assert in the same cycle.
6. Ch1 in PENDING with counter=2, then reset asserted 1 cycle with raw held high -> all outputs 0 next cycle, no pulse. After release, rise_pulse[1] fires after full re-qualification (>=11 cycles).
   Also rerun with TICK_DIV=1, STABLE_TICKS=1 -> level follows sync with 1 extra cycle.
